mul_div_unit: RTL and testbench

- Iterative multiply/divide unit in the EX stage, beside the combinational ALU. It executes MULT, MULTU, DIV and DIVU, and holds the architectural HI/LO registers.
- It is the sequential counterpart of the ALU: it accepts an operation with a start pulse and reports completion through a busy/done handshake.
- The pipeline stalls on busy.
- MFHI/MFLO read the hi/lo outputs; MTHI/MTLO write through hi_we/lo_we.

---
 rtl/mul_div_unit_pkg.sv | 30 +++
 rtl/mul_div_unit_if.sv | 28 ++
 rtl/mul_div_unit_iter_step.sv | 35 +++
 rtl/mul_div_unit.sv | 157 +++++++++++++++
 tb/tb_mul_div_unit.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation codes,
// FSM state encoding, default width and latency, and small op-decode helpers.
package md_pkg;

  localparam int MD_WIDTH   = 32;
  localparam int MD_LATENCY = MD_WIDTH + 1;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } md_state_e;

  // Bit 1 of the op code selects divide, bit 0 selects the unsigned variant
  function automatic logic md_is_div(input md_op_e op);
    return op[1];
  endfunction

  function automatic logic md_is_signed(input md_op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Pipeline-facing bundle of the multiply/divide unit: request, MTHI/MTLO
// writes, flush, and the busy/done/HI/LO results.
interface mul_div_unit_if #(parameter int WIDTH = 32);

  logic             start;
  logic [1:0]       md_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, md_op, a, b, hi_we, lo_we, wdata, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, md_op, a, b, hi_we, lo_we, wdata, flush,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/mul_div_unit_iter_step.sv
// One iteration of the shared multiply/divide datapath. The accumulator holds
// {partial, operand-bits}: shift-add for multiply, restoring subtract for divide.
module md_iter_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // Multiply consumes the multiplier LSB-first; divide brings the dividend in MSB-first
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    trial    = shifted - {1'b0, opnd};
    acc_next = acc;
    if (is_div) begin
      if (!trial[WIDTH]) begin
        acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
    end else if (acc[0]) begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end else begin
      acc_next = {1'b0, acc[2*WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers. Works on
// magnitudes for WIDTH cycles, then applies sign correction in a single FIX cycle.
module mul_div_unit
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  mul_div_unit_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  md_state_e          state;
  md_state_e          state_next;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   a_raw;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  md_op_e             op_q;
  logic               neg_q;
  logic               neg_rem_q;
  logic               div_zero_q;
  logic               done_q;

  logic               busy;
  logic               accept;
  logic               fix_write;
  logic               last_iter;

  md_op_e             op_in;
  logic               in_signed;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   quot_fixed;
  logic [WIDTH-1:0]   rem_fixed;
  logic [WIDTH-1:0]   hi_res;
  logic [WIDTH-1:0]   lo_res;

  assign op_in     = md_op_e'(bus.md_op);
  assign in_signed = md_is_signed(op_in);
  assign a_mag     = (in_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign b_mag     = (in_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  assign last_iter = (state == CALC) && (cnt == CW'(WIDTH - 1));

  md_iter_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (md_is_div(op_q)),
    .acc      (acc),
    .opnd     (opnd),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.start && !bus.flush) state_next = CALC;
      CALC: begin
        if (bus.flush) begin
          state_next = IDLE;
        end else if (last_iter) begin
          state_next = FIX;
        end
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    accept    = (state == IDLE) && bus.start && !bus.flush;
    fix_write = (state == FIX) && !bus.flush;
  end

  // Divide-by-zero bypasses sign correction: HI is the raw dividend, LO all ones
  always_comb begin
    prod_fixed = neg_q ? -acc : acc;
    quot_fixed = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fixed  = neg_rem_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    hi_res     = prod_fixed[2*WIDTH-1:WIDTH];
    lo_res     = prod_fixed[WIDTH-1:0];
    if (md_is_div(op_q)) begin
      if (div_zero_q) begin
        hi_res = a_raw;
        lo_res = '1;
      end else begin
        hi_res = rem_fixed;
        lo_res = quot_fixed;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      acc        <= '0;
      opnd       <= '0;
      a_raw      <= '0;
      op_q       <= MD_MULT;
      neg_q      <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else if (accept) begin
      cnt        <= '0;
      op_q       <= op_in;
      acc        <= md_is_div(op_in) ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
      opnd       <= md_is_div(op_in) ? b_mag : a_mag;
      a_raw      <= bus.a;
      neg_q      <= in_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      neg_rem_q  <= in_signed && bus.a[WIDTH-1];
      div_zero_q <= (bus.b == '0);
    end else if (state == CALC) begin
      acc <= acc_next;
      cnt <= cnt + CW'(1);
    end else begin
      cnt <= '0;
    end
  end

  // MTHI/MTLO only land in IDLE and lose to an accepted start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= fix_write;
      if (fix_write) begin
        hi_q <= hi_res;
        lo_q <= lo_res;
      end else if ((state == IDLE) && !accept) begin
        if (bus.hi_we) hi_q <= bus.wdata;
        if (bus.lo_we) lo_q <= bus.wdata;
      end
    end
  end

  assign bus.busy = busy;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: table of arithmetic vectors with
// hand-computed HI/LO, plus flush, MTHI/MTLO and reset sequences.
module tb_mul_div_unit;

  localparam int W = 32;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  logic clk;
  logic rst;
  int   n_compared;
  int   n_mismatched;
  vec_t vecs[13];

  mul_div_unit_if #(.WIDTH(W)) bus ();

  mul_div_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Starts an op and returns at the negedge of the done cycle (or after the
  // cycle bound). At poke_cycle it drives a stray start and an MTHI write.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               input int poke_cycle, output int busy_cycles, output bit got_done);
    @(negedge clk);
    bus.start = 1'b1;
    bus.md_op = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start   = 1'b0;
    busy_cycles = 0;
    got_done    = 1'b0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      if (bus.done) begin
        got_done = 1'b1;
        break;
      end
      if (bus.busy) busy_cycles++;
      if (cyc == poke_cycle) begin
        bus.start = 1'b1;
        bus.md_op = 2'd1;
        bus.a     = 32'hFFFF_FFFF;
        bus.b     = 32'hFFFF_FFFF;
        bus.hi_we = 1'b1;
        bus.wdata = 32'hDEAD_BEEF;
      end else begin
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
  endtask

  task automatic waitDone(output bit got_done);
    got_done = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (bus.done) begin
        got_done = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int busy_cycles;
    bit got_done;
    int done_count;

    n_compared   = 0;
    n_mismatched = 0;

    vecs[0]  = '{"mult_neg3x5",     2'd0, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[1]  = '{"multu_max",       2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2]  = '{"div_neg7by2",     2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3]  = '{"divu_100by7",     2'd3, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
    vecs[4]  = '{"divu_by0",        2'd3, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF};
    vecs[5]  = '{"div_min_by_m1",   2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[6]  = '{"mult_7xneg6",     2'd0, 32'h0000_0007, 32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFD6};
    vecs[7]  = '{"div_7byneg2",     2'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[8]  = '{"div_neg7byneg2",  2'd2, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003};
    vecs[9]  = '{"multu_carry",     2'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
    vecs[10] = '{"div_neg5_by0",    2'd2, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF};
    vecs[11] = '{"mult_min_sq",     2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[12] = '{"mult_0xneg1",     2'd0, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.md_op = 2'd0;
    bus.a     = '0;
    bus.b     = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    bus.flush = 1'b0;

    #12;
    checkOutput("reset_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("reset_done", {31'd0, bus.done}, 32'd0);
    checkOutput("reset_hi", bus.hi, 32'd0);
    checkOutput("reset_lo", bus.lo, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, 0, busy_cycles, got_done);
      checkOutput({vecs[i].name, "_done"}, {31'd0, got_done}, 32'd1);
      checkOutput({vecs[i].name, "_busy_cycles"}, busy_cycles, 32'd33);
      checkOutput({vecs[i].name, "_hi"}, bus.hi, vecs[i].exp_hi);
      checkOutput({vecs[i].name, "_lo"}, bus.lo, vecs[i].exp_lo);
      checkOutput({vecs[i].name, "_busy_at_done"}, {31'd0, bus.busy}, 32'd0);
      @(negedge clk);
      checkOutput({vecs[i].name, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
    end

    // MTHI then MTLO in IDLE
    bus.hi_we = 1'b1;
    bus.wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    bus.hi_we = 1'b0;
    checkOutput("mthi_hi", bus.hi, 32'hA5A5_A5A5);
    checkOutput("mthi_lo_kept", bus.lo, 32'h0000_0000);
    bus.lo_we = 1'b1;
    bus.wdata = 32'h5A5A_5A5A;
    @(negedge clk);
    bus.lo_we = 1'b0;
    checkOutput("mtlo_lo", bus.lo, 32'h5A5A_5A5A);

    // Flush at cycle 10 of a MULTU
    bus.start = 1'b1;
    bus.md_op = 2'd1;
    bus.a     = 32'd3;
    bus.b     = 32'd4;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    checkOutput("flush_busy_before", {31'd0, bus.busy}, 32'd1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    checkOutput("flush_busy", {31'd0, bus.busy}, 32'd0);
    done_count = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (bus.done) done_count++;
      @(negedge clk);
    end
    checkOutput("flush_no_done", done_count, 32'd0);
    checkOutput("flush_hi_kept", bus.hi, 32'hA5A5_A5A5);
    checkOutput("flush_lo_kept", bus.lo, 32'h5A5A_5A5A);

    // Stray start and MTHI while busy are both ignored
    applyStimulus(2'd3, 32'd100, 32'd7, 5, busy_cycles, got_done);
    checkOutput("busy_start_done", {31'd0, got_done}, 32'd1);
    checkOutput("busy_start_cycles", busy_cycles, 32'd33);
    checkOutput("busy_start_hi", bus.hi, 32'h0000_0002);
    checkOutput("busy_start_lo", bus.lo, 32'h0000_000E);
    @(negedge clk);
    checkOutput("busy_start_idle", {31'd0, bus.busy}, 32'd0);

    // MTHI/MTLO in the same cycle as start are dropped
    bus.start = 1'b1;
    bus.md_op = 2'd1;
    bus.a     = 32'd2;
    bus.b     = 32'd3;
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'h1111_1111;
    @(negedge clk);
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    waitDone(got_done);
    checkOutput("start_wins_done", {31'd0, got_done}, 32'd1);
    checkOutput("start_wins_hi", bus.hi, 32'h0000_0000);
    checkOutput("start_wins_lo", bus.lo, 32'h0000_0006);

    // MTHI in the done cycle overrides the result one cycle later
    bus.hi_we = 1'b1;
    bus.wdata = 32'h2222_2222;
    @(negedge clk);
    bus.hi_we = 1'b0;
    checkOutput("done_mthi_hi", bus.hi, 32'h2222_2222);
    checkOutput("done_mthi_lo", bus.lo, 32'h0000_0006);

    // start with flush in IDLE is ignored
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.md_op = 2'd0;
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    checkOutput("flush_start_idle", {31'd0, bus.busy}, 32'd0);

    // Async reset mid-operation
    bus.start = 1'b1;
    bus.md_op = 2'd3;
    bus.a     = 32'd100;
    bus.b     = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("rst_mid_hi", bus.hi, 32'd0);
    checkOutput("rst_mid_lo", bus.lo, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(2'd3, 32'd100, 32'd7, 0, busy_cycles, got_done);
    checkOutput("post_rst_done", {31'd0, got_done}, 32'd1);
    checkOutput("post_rst_hi", bus.hi, 32'h0000_0002);
    checkOutput("post_rst_lo", bus.lo, 32'h0000_000E);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
